// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 responder running entirely on the local clk.
// SCLK, CS_N and MOSI are oversampled through synchronisers. MOSI is deserialised into words.
// MISO is serialised from a single-entry valid/ready holding register.
module spi_slave_byte_if #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Synchroniser chains: bit 0 is the first flop, bit 1 the usable value, bit 2 the edge reference.
    logic [2:0] sclk_sync_reg;
    logic [2:0] cs_sync_reg;
    logic [1:0] mosi_sync_reg;

    logic [DATA_WIDTH-1:0] tx_sr_reg;
    logic [DATA_WIDTH-1:0] rx_sr_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  hold_full_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic                  word_done_reg;
    logic                  miso_reg;
    logic                  miso_oe_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic                  rx_valid_reg;
    logic                  tx_underrun_reg;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic start_frame, end_frame, load_tx, shift_tx, capture;
    logic                  tx_accept;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] rx_word;

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
    assign cs_fall   = ~cs_sync_reg[1] & cs_sync_reg[2];
    assign cs_rise   = cs_sync_reg[1] & ~cs_sync_reg[2];

    assign tx_accept = tx_valid & ~hold_full_reg;
    // An empty holding register at a word boundary sends the idle fill pattern.
    assign load_word = hold_full_reg ? hold_reg : IDLE_FILL;
    assign rx_word   = {rx_sr_reg[DATA_WIDTH-2:0], mosi_sync_reg[1]};

    assign spi_miso    = miso_reg;
    assign spi_miso_oe = miso_oe_reg;
    assign tx_ready    = ~hold_full_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign tx_underrun = tx_underrun_reg;
    assign busy        = ~cs_sync_reg[1];

    // Oversample the asynchronous SPI pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= 3'b000;
            cs_sync_reg   <= 3'b111;
            mosi_sync_reg <= 2'b00;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], spi_sclk};
            cs_sync_reg   <= {cs_sync_reg[1:0], spi_cs_n};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
        end
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and per-cycle datapath strobes; a CS rise overrides any SCLK edge in the same cycle.
    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        load_tx     = 1'b0;
        shift_tx    = 1'b0;
        capture     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = ACTIVE;
                    start_frame = 1'b1;
                    load_tx     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    end_frame  = 1'b1;
                end else if (!cs_sync_reg[1] && sclk_rise) begin
                    capture = 1'b1;
                end else if (!cs_sync_reg[1] && sclk_fall) begin
                    if (word_done_reg) begin
                        load_tx = 1'b1;
                    end else begin
                        shift_tx = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // TX holding register: a reload empties it, and it is refilled only while it is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else if (tx_accept) begin
            hold_reg      <= tx_data;
            hold_full_reg <= 1'b1;
        end else if (load_tx && hold_full_reg) begin
            hold_full_reg <= 1'b0;
        end
    end

    // Shift registers, bit counter and MISO drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr_reg       <= '0;
            rx_sr_reg       <= '0;
            bit_cnt_reg     <= '0;
            word_done_reg   <= 1'b0;
            miso_reg        <= 1'b0;
            miso_oe_reg     <= 1'b0;
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            tx_underrun_reg <= 1'b0;
        end else begin
            rx_valid_reg    <= 1'b0;
            tx_underrun_reg <= 1'b0;
            if (end_frame) begin
                // Partial receive words and any word already in tx_sr are dropped.
                bit_cnt_reg   <= '0;
                word_done_reg <= 1'b0;
                miso_reg      <= 1'b0;
                miso_oe_reg   <= 1'b0;
            end else begin
                if (start_frame) begin
                    bit_cnt_reg <= '0;
                    miso_oe_reg <= 1'b1;
                end
                if (load_tx) begin
                    tx_sr_reg       <= load_word;
                    miso_reg        <= load_word[DATA_WIDTH-1];
                    word_done_reg   <= 1'b0;
                    tx_underrun_reg <= ~hold_full_reg;
                end
                if (shift_tx) begin
                    tx_sr_reg <= {tx_sr_reg[DATA_WIDTH-2:0], 1'b0};
                    miso_reg  <= tx_sr_reg[DATA_WIDTH-2];
                end
                if (capture) begin
                    rx_sr_reg <= rx_word;
                    if (bit_cnt_reg == LAST_BIT) begin
                        rx_data_reg   <= rx_word;
                        rx_valid_reg  <= 1'b1;
                        bit_cnt_reg   <= '0;
                        word_done_reg <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Self-checking bench for spi_slave_byte_if: a behavioural SPI mode-0 master plus an RX scoreboard.
module tb_spi_slave_byte_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int          total = 0;
    int          bad = 0;
    int          underrun_cnt = 0;
    logic [7:0]  rx_exp_q[$];
    logic [15:0] miso_cap;

    spi_slave_byte_if #(.DATA_WIDTH(8), .IDLE_FILL(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Scoreboard: every rx_valid pulse pops one expected word.
    task automatic monitor();
        logic [7:0] exp_word;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                total++;
                if (rx_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rx_unexpected: got rx_data=%h, required no rx_valid", rx_data);
                end else begin
                    exp_word = rx_exp_q.pop_front();
                    if (rx_data !== exp_word) begin
                        bad++;
                        $display("FAIL rx_data: got %h, required %h", rx_data, exp_word);
                    end else begin
                        $display("rx word %h", rx_data);
                    end
                end
            end
            if (tx_underrun === 1'b1) underrun_cnt++;
        end
    endtask

    // Master frame: SCLK period = 6 clk, MISO sampled on each rising SCLK.
    // The last falling SCLK coincides with CS deassertion.
    task automatic spi_xfer(input logic [15:0] bits, input int nbits);
        miso_cap = '0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = bits[15];
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b1;
            miso_cap[15-i] = spi_miso;
            if (i == 0) begin
                total++;
                if (spi_miso_oe !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL frame_active: got oe=%b busy=%b, required 1 1", spi_miso_oe, busy);
                end
            end
            repeat (3) @(negedge clk);
            spi_sclk = 1'b0;
            if (i == nbits - 1) spi_cs_n = 1'b1;
            else spi_mosi = bits[14-i];
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        $display("frame %0d bits mosi=%h miso=%h", nbits, bits, miso_cap);
    endtask

    // Offer one TX word once tx_ready is seen, bounded wait.
    task automatic tx_push(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL tx_ready_timeout: got tx_ready=%b, required 1", tx_ready);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            $display("tx push %h", d);
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: got oe=%b miso=%b busy=%b, required 0 0 0", name, spi_miso_oe, spi_miso, busy);
        end
        total++;
        if (rx_exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_rx_pending: got %0d words missing, required 0", name, rx_exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tx_data = '0;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0 || tx_ready !== 1'b1 || rx_data !== 8'h00 ||
            rx_valid !== 1'b0 || tx_underrun !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got miso=%b oe=%b rdy=%b rx=%h rv=%b ur=%b busy=%b, required 0 0 1 00 0 0 0",
                     spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (tx_ready !== 1'b1 || spi_miso_oe !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got rdy=%b oe=%b, required 1 0", tx_ready, spi_miso_oe);
        end
        $display("reset done");
    endtask

    task automatic test_single_byte();
        tx_push(8'hA5);
        total++;
        if (tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_full: got tx_ready=%b, required 0", tx_ready);
        end
        underrun_cnt = 0;
        rx_exp_q.push_back(8'h3C);
        spi_xfer({8'h3C, 8'h00}, 8);
        total++;
        if (miso_cap[15:8] !== 8'hA5) begin
            bad++;
            $display("FAIL single_miso: got %h, required a5", miso_cap[15:8]);
        end
        total++;
        if (underrun_cnt != 0) begin
            bad++;
            $display("FAIL single_underrun: got %0d, required 0", underrun_cnt);
        end
        check_idle("single_end");
    endtask

    task automatic test_back_to_back();
        tx_push(8'h11);
        underrun_cnt = 0;
        rx_exp_q.push_back(8'hF0);
        rx_exp_q.push_back(8'h0F);
        fork
            spi_xfer({8'hF0, 8'h0F}, 16);
            tx_push(8'h22);
        join
        total++;
        if (miso_cap !== 16'h1122) begin
            bad++;
            $display("FAIL b2b_miso: got %h, required 1122", miso_cap);
        end
        total++;
        if (underrun_cnt != 0 || tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_underrun: got count=%0d rdy=%b, required 0 1", underrun_cnt, tx_ready);
        end
        check_idle("b2b_end");
    endtask

    task automatic test_underrun();
        underrun_cnt = 0;
        rx_exp_q.push_back(8'hC3);
        rx_exp_q.push_back(8'h7E);
        spi_xfer({8'hC3, 8'h7E}, 16);
        total++;
        if (miso_cap !== 16'h0000) begin
            bad++;
            $display("FAIL underrun_miso: got %h, required 0000", miso_cap);
        end
        total++;
        if (underrun_cnt != 2) begin
            bad++;
            $display("FAIL underrun_count: got %0d, required 2", underrun_cnt);
        end
        check_idle("underrun_end");
    endtask

    task automatic test_abort();
        spi_xfer({8'hFF, 8'h00}, 5);
        check_idle("abort_end");
        rx_exp_q.push_back(8'h81);
        spi_xfer({8'h81, 8'h00}, 8);
        check_idle("after_abort");
    endtask

    task automatic test_async_reset();
        tx_push(8'h77);
        @(negedge clk);
        spi_cs_n = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b1;
        tx_push(8'h99);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            spi_sclk = 1'b1;
            repeat (3) @(negedge clk);
            spi_sclk = 1'b0;
            spi_mosi = ~spi_mosi;
            repeat (3) @(negedge clk);
        end
        spi_sclk = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_state: got rdy=%b busy=%b, required 0 1", tx_ready, busy);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        #1;
        total++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0 ||
            rx_valid !== 1'b0 || rx_data !== 8'h00 || tx_underrun !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got oe=%b miso=%b rdy=%b busy=%b rv=%b rx=%h ur=%b, required 0 0 1 0 0 00 0",
                     spi_miso_oe, spi_miso, tx_ready, busy, rx_valid, rx_data, tx_underrun);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        underrun_cnt = 0;
        rx_exp_q.push_back(8'h5A);
        spi_xfer({8'h5A, 8'h00}, 8);
        total++;
        if (miso_cap[15:8] !== 8'h00 || underrun_cnt != 1) begin
            bad++;
            $display("FAIL reset_next_frame: got miso=%h underruns=%0d, required 00 1", miso_cap[15:8], underrun_cnt);
        end
        check_idle("reset_end");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_async_reset();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
